// File: rtl/io_bus_ctrl_pkg.sv
// Address map and status-register layout shared by the I/O controller and the CPU top level.
package io_bus_ctrl_pkg;

  localparam logic [31:0] ADDRHEX   = 32'hF000_0000;
  localparam logic [31:0] ADDRLEDR  = 32'hF000_0004;
  localparam logic [31:0] ADDRLEDG  = 32'hF000_0008;
  localparam logic [31:0] ADDRKEY   = 32'hF000_0010;
  localparam logic [31:0] ADDRSW    = 32'hF000_0014;
  localparam logic [31:0] ADDRKCTRL = 32'hF000_0110;
  localparam logic [31:0] ADDRSCTRL = 32'hF000_0114;

  localparam int CTRL_READY   = 0;
  localparam int CTRL_OVERRUN = 2;

  localparam logic [31:0] RDATA_UNMAPPED = 32'hDEAD_BEEF;
  localparam logic [15:0] HEX_RESET      = 16'hDEAD;

  typedef struct packed {
    logic overrun;
    logic ready;
  } io_status_t;

  function automatic logic [31:0] ctrl_word(input io_status_t s);
    logic [31:0] w;
    w               = '0;
    w[CTRL_READY]   = s.ready;
    w[CTRL_OVERRUN] = s.overrun;
    return w;
  endfunction

  // A change pulse always wins; a data read or ctrl write in the same cycle acts as the
  // acknowledgement, so that pulse cannot raise overrun.
  function automatic io_status_t status_next(input io_status_t cur, input logic chg,
                                             input logic rd_data, input logic wr_ctrl,
                                             input logic keep_ready, input logic keep_overrun);
    io_status_t nxt;
    nxt = cur;
    if (chg) begin
      nxt.ready = 1'b1;
      if (!rd_data && !wr_ctrl) nxt.overrun = cur.overrun | cur.ready;
    end else begin
      if (rd_data) nxt.ready = 1'b0;
      if (wr_ctrl) begin
        nxt.ready   = cur.ready & keep_ready;
        nxt.overrun = cur.overrun & keep_overrun;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus debouncer: an input value must hold for DEBOUNCE synchronised
// cycles before it replaces the stable value; o_chg pulses in the cycle stable updates.
module io_debounce #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 500000,
  parameter int CNTBITS  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_stable,
  output logic             o_chg
);

  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE - 1);

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [WIDTH-1:0]   r_cand;
  logic [WIDTH-1:0]   r_stable;
  logic [CNTBITS-1:0] r_cnt;

  assign o_chg    = (r_sync2 == r_cand) && (r_cnt == CNT_LAST) && (r_cand != r_stable);
  assign o_stable = r_stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (o_chg) begin
        r_stable <= r_cand;
      end else if (r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + CNTBITS'(1);
      end
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O on the memory-stage data bus: HEX/LEDR/LEDG output registers,
// debounced KEY/SW inputs with sticky ready/overrun status, and the combinational read mux.
module io_bus_ctrl #(
  parameter int DBITS    = 32,
  parameter int DEBOUNCE = 500000,
  parameter int CNTBITS  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic [DBITS-1:0] rdata,
  output logic             hit,
  input  logic [3:0]       key_n,
  input  logic [9:0]       sw,
  output logic [15:0]      hex_out,
  output logic [9:0]       ledr,
  output logic [7:0]       ledg
);

  import io_bus_ctrl_pkg::*;

  logic [3:0] w_key;
  logic [3:0] w_key_stable;
  logic       w_key_chg;
  logic [9:0] w_sw_stable;
  logic       w_sw_chg;
  logic       w_sel_hex, w_sel_ledr, w_sel_ledg, w_sel_key, w_sel_sw, w_sel_kctrl, w_sel_sctrl;
  logic       w_unused_wdata;

  logic [15:0] r_hex;
  logic [9:0]  r_ledr;
  logic [7:0]  r_ledg;
  io_status_t  r_kstat;
  io_status_t  r_sstat;

  assign w_key = ~key_n;

  io_debounce #(.WIDTH(4), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS)) u_key_db (
    .clk      (clk),
    .reset    (reset),
    .i_din    (w_key),
    .o_stable (w_key_stable),
    .o_chg    (w_key_chg)
  );

  io_debounce #(.WIDTH(10), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS)) u_sw_db (
    .clk      (clk),
    .reset    (reset),
    .i_din    (sw),
    .o_stable (w_sw_stable),
    .o_chg    (w_sw_chg)
  );

  assign w_sel_hex   = (addr == DBITS'(ADDRHEX));
  assign w_sel_ledr  = (addr == DBITS'(ADDRLEDR));
  assign w_sel_ledg  = (addr == DBITS'(ADDRLEDG));
  assign w_sel_key   = (addr == DBITS'(ADDRKEY));
  assign w_sel_sw    = (addr == DBITS'(ADDRSW));
  assign w_sel_kctrl = (addr == DBITS'(ADDRKCTRL));
  assign w_sel_sctrl = (addr == DBITS'(ADDRSCTRL));

  assign w_unused_wdata = ^wdata[DBITS-1:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hex   <= HEX_RESET;
      r_ledr  <= '0;
      r_ledg  <= '0;
      r_kstat <= '0;
      r_sstat <= '0;
    end else begin
      if (we && w_sel_hex)  r_hex  <= wdata[15:0];
      if (we && w_sel_ledr) r_ledr <= wdata[9:0];
      if (we && w_sel_ledg) r_ledg <= wdata[7:0];
      r_kstat <= status_next(r_kstat, w_key_chg, re && w_sel_key, we && w_sel_kctrl,
                             wdata[CTRL_READY], wdata[CTRL_OVERRUN]);
      r_sstat <= status_next(r_sstat, w_sw_chg, re && w_sel_sw, we && w_sel_sctrl,
                             wdata[CTRL_READY], wdata[CTRL_OVERRUN]);
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns rdata and hit, leaving no latch.
    rdata = DBITS'(RDATA_UNMAPPED);
    hit   = 1'b1;
    if      (w_sel_hex)   rdata = DBITS'(r_hex);
    else if (w_sel_ledr)  rdata = DBITS'(r_ledr);
    else if (w_sel_ledg)  rdata = DBITS'(r_ledg);
    else if (w_sel_key)   rdata = DBITS'(w_key_stable);
    else if (w_sel_sw)    rdata = DBITS'(w_sw_stable);
    else if (w_sel_kctrl) rdata = DBITS'(ctrl_word(r_kstat));
    else if (w_sel_sctrl) rdata = DBITS'(ctrl_word(r_sstat));
    else                  hit   = 1'b0;
  end

  assign hex_out = r_hex;
  assign ledr    = r_ledr;
  assign ledg    = r_ledg;

endmodule
